// File: rtl/wb_regfile_sb_pkg.sv
// Shared constants and the MEM2->WB write-back bundle for the multithreaded
// integer register file (wb_regfile_sb).
package wb_regfile_sb_pkg;

   // Default geometry: 8 hardware threads x 32 registers x 64 bits.
   localparam int DEF_DATA_WIDTH        = 64;
   localparam int DEF_REG_INDEX_BITS    = 5;
   localparam int DEF_THREAD_INDEX_BITS = 3;
   localparam int NUM_REGS              = 1 << DEF_REG_INDEX_BITS;
   localparam int NUM_THREADS           = 1 << DEF_THREAD_INDEX_BITS;

   // Write-back bundle as carried by the MEM2/WB pipeline registers.
   // Valid semantics: 'flag' qualifies the whole bundle for exactly one
   // cycle; there is no ready, the register file always accepts a write.
   // When 'flag' is low the remaining fields are don't-care.
   typedef struct packed {
      logic                             flag;
      logic [DEF_REG_INDEX_BITS-1:0]    reg_index;
      logic [DEF_THREAD_INDEX_BITS-1:0] thread_index;
      logic [DEF_DATA_WIDTH-1:0]        data;
   } wb_bundle_t;

endpackage

// File: rtl/wb_regfile_sb_scoreboard.sv
// wb_scoreboard: per-thread, per-register pending-write bits.
// Issue sets a bit, write-back clears it, set wins on a same-entry collision.
// Busy lookups hide an entry that is being cleared this cycle, since the
// read path bypasses the write-back data in that case.
// Optional checker enabled by the macro WB_SB_CHECK_EN (adds sb_error).
module wb_scoreboard
   import wb_regfile_sb_pkg::*;
#(
   parameter int REG_INDEX_BITS    = DEF_REG_INDEX_BITS,
   parameter int THREAD_INDEX_BITS = DEF_THREAD_INDEX_BITS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr_valid,
   input  logic [THREAD_INDEX_BITS-1:0] clr_thread,
   input  logic [REG_INDEX_BITS-1:0]    clr_reg,
   input  logic                         set_valid,
   input  logic [THREAD_INDEX_BITS-1:0] set_thread,
   input  logic [REG_INDEX_BITS-1:0]    set_reg,
   input  logic [THREAD_INDEX_BITS-1:0] rd_thread,
   input  logic [REG_INDEX_BITS-1:0]    rd_a_index,
   input  logic [REG_INDEX_BITS-1:0]    rd_b_index,
   output logic                         rd_a_busy,
   output logic                         rd_b_busy
`ifdef WB_SB_CHECK_EN
   ,
   output logic                         sb_error
`endif
);

   localparam int ADDR_BITS   = THREAD_INDEX_BITS + REG_INDEX_BITS;
   localparam int NUM_ENTRIES = 1 << ADDR_BITS;

   logic [NUM_ENTRIES-1:0] pending;
   logic [NUM_ENTRIES-1:0] pending_next;
   logic [ADDR_BITS-1:0]   clr_addr;
   logic [ADDR_BITS-1:0]   set_addr;
   logic [ADDR_BITS-1:0]   a_addr;
   logic [ADDR_BITS-1:0]   b_addr;
   logic                   clr_hit;
   logic                   set_hit;

   // Register 0 is hard-wired: it is never marked pending nor cleared.
   assign clr_addr = {clr_thread, clr_reg};
   assign set_addr = {set_thread, set_reg};
   assign a_addr   = {rd_thread, rd_a_index};
   assign b_addr   = {rd_thread, rd_b_index};
   assign clr_hit  = clr_valid && (clr_reg != '0);
   assign set_hit  = set_valid && (set_reg != '0);

   // Next pending state: clear first, then set, so a same-entry set wins.
   always_comb begin
      pending_next = pending;
      if (clr_hit) pending_next[clr_addr] = 1'b0;
      if (set_hit) pending_next[set_addr] = 1'b1;
   end

   // Pending bit array; reset drops every outstanding write.
   always_ff @(posedge clk) begin
      if (reset) pending <= '0;
      else       pending <= pending_next;
   end

   // Busy ignores same-cycle sets and masks an entry cleared this cycle.
   assign rd_a_busy = pending[a_addr] && !(clr_hit && (clr_addr == a_addr));
   assign rd_b_busy = pending[b_addr] && !(clr_hit && (clr_addr == b_addr));

`ifdef WB_SB_CHECK_EN
   // Sticky flag for a write-back that no issued producer accounts for.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_error <= 1'b0;
      end else if (clr_hit && !pending[clr_addr] &&
                   !(set_hit && (set_addr == clr_addr))) begin
         sb_error <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb: multithreaded integer register file, write-back consumer.
// One write port from MEM2/WB, two registered read ports with same-cycle
// write bypass, and a pending-write scoreboard (wb_scoreboard).
// Optional scoreboard checker enabled by the macro WB_SB_CHECK_EN.
module wb_regfile_sb
   import wb_regfile_sb_pkg::*;
#(
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int REG_INDEX_BITS    = DEF_REG_INDEX_BITS,
   parameter int THREAD_INDEX_BITS = DEF_THREAD_INDEX_BITS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wb_write_back_flag,
   input  logic [REG_INDEX_BITS-1:0]    wb_reg_index,
   input  logic [THREAD_INDEX_BITS-1:0] wb_thread_index,
   input  logic [DATA_WIDTH-1:0]        wb_data,
   input  logic                         rd_en,
   input  logic [THREAD_INDEX_BITS-1:0] rd_thread_index,
   input  logic [REG_INDEX_BITS-1:0]    rd_a_index,
   input  logic [REG_INDEX_BITS-1:0]    rd_b_index,
   output logic [DATA_WIDTH-1:0]        rd_a_data,
   output logic [DATA_WIDTH-1:0]        rd_b_data,
   output logic                         rd_a_busy,
   output logic                         rd_b_busy,
   input  logic                         sb_set_valid,
   input  logic [THREAD_INDEX_BITS-1:0] sb_set_thread,
   input  logic [REG_INDEX_BITS-1:0]    sb_set_reg
`ifdef WB_SB_CHECK_EN
   ,
   output logic                         sb_error
`endif
);

   localparam int ADDR_BITS   = THREAD_INDEX_BITS + REG_INDEX_BITS;
   localparam int NUM_ENTRIES = 1 << ADDR_BITS;

   wb_bundle_t           wb;
   logic                 wb_we;
   logic [ADDR_BITS-1:0] wb_addr;
   logic [ADDR_BITS-1:0] a_addr;
   logic [ADDR_BITS-1:0] b_addr;
   logic [DATA_WIDTH-1:0] a_value;
   logic [DATA_WIDTH-1:0] b_value;
   logic [DATA_WIDTH-1:0] regs [NUM_ENTRIES];

   assign wb = '{flag:         wb_write_back_flag,
                 reg_index:    wb_reg_index,
                 thread_index: wb_thread_index,
                 data:         wb_data};

   // Writes to register 0 are dropped; writes during reset are ignored.
   assign wb_we   = wb.flag && (wb.reg_index != '0) && !reset;
   assign wb_addr = {wb.thread_index, wb.reg_index};
   assign a_addr  = {rd_thread_index, rd_a_index};
   assign b_addr  = {rd_thread_index, rd_b_index};

   // Register array: no reset, contents undefined until first written.
   always_ff @(posedge clk) begin
      if (wb_we) regs[wb_addr] <= wb.data;
   end

   // Per-port read value: r0 reads zero, same-cycle write is bypassed.
   always_comb begin
      a_value = regs[a_addr];
      b_value = regs[b_addr];
      if (wb_we && (wb_addr == a_addr)) a_value = wb.data;
      if (wb_we && (wb_addr == b_addr)) b_value = wb.data;
      if (rd_a_index == '0) a_value = '0;
      if (rd_b_index == '0) b_value = '0;
   end

   // Read data registers: load on rd_en, hold otherwise, zero on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_a_data <= '0;
         rd_b_data <= '0;
      end else if (rd_en) begin
         rd_a_data <= a_value;
         rd_b_data <= b_value;
      end
   end

   wb_scoreboard #(
      .REG_INDEX_BITS    (REG_INDEX_BITS),
      .THREAD_INDEX_BITS (THREAD_INDEX_BITS)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .clr_valid  (wb.flag),
      .clr_thread (wb.thread_index),
      .clr_reg    (wb.reg_index),
      .set_valid  (sb_set_valid),
      .set_thread (sb_set_thread),
      .set_reg    (sb_set_reg),
      .rd_thread  (rd_thread_index),
      .rd_a_index (rd_a_index),
      .rd_b_index (rd_b_index),
      .rd_a_busy  (rd_a_busy),
      .rd_b_busy  (rd_b_busy)
`ifdef WB_SB_CHECK_EN
      ,
      .sb_error   (sb_error)
`endif
   );

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Testbench for wb_regfile_sb: directed vectors, expected values queued by
// the driver and popped by a negedge monitor.
module tb_wb_regfile_sb;

   localparam int DW = 64;
   localparam int RB = 5;
   localparam int TB = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          wb_write_back_flag = 1'b0;
   logic [RB-1:0] wb_reg_index = '0;
   logic [TB-1:0] wb_thread_index = '0;
   logic [DW-1:0] wb_data = '0;
   logic          rd_en = 1'b0;
   logic [TB-1:0] rd_thread_index = '0;
   logic [RB-1:0] rd_a_index = '0;
   logic [RB-1:0] rd_b_index = '0;
   logic [DW-1:0] rd_a_data;
   logic [DW-1:0] rd_b_data;
   logic          rd_a_busy;
   logic          rd_b_busy;
   logic          sb_set_valid = 1'b0;
   logic [TB-1:0] sb_set_thread = '0;
   logic [RB-1:0] sb_set_reg = '0;
`ifdef WB_SB_CHECK_EN
   logic          sb_error;
`endif

   wb_regfile_sb dut (
      .clk                (clk),
      .reset              (reset),
      .wb_write_back_flag (wb_write_back_flag),
      .wb_reg_index       (wb_reg_index),
      .wb_thread_index    (wb_thread_index),
      .wb_data            (wb_data),
      .rd_en              (rd_en),
      .rd_thread_index    (rd_thread_index),
      .rd_a_index         (rd_a_index),
      .rd_b_index         (rd_b_index),
      .rd_a_data          (rd_a_data),
      .rd_b_data          (rd_b_data),
      .rd_a_busy          (rd_a_busy),
      .rd_b_busy          (rd_b_busy),
      .sb_set_valid       (sb_set_valid),
      .sb_set_thread      (sb_set_thread),
      .sb_set_reg         (sb_set_reg)
`ifdef WB_SB_CHECK_EN
      ,
      .sb_error           (sb_error)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] exp_a_q[$];
   logic [DW-1:0] exp_b_q[$];
   logic [1:0]    exp_busy_q[$];
   logic [0:0]    exp_err_q[$];
   int checks = 0;
   int errors = 0;

   logic hold_req  = 1'b0;  // expect rd data unchanged after next edge
   logic busy_chk  = 1'b0;  // expect busy value in this cycle
   logic err_chk   = 1'b0;  // expect sb_error value in this cycle
   logic data_fire = 1'b0;  // rd data registers should present a value

   // Data is visible one edge after a read, a reset, or a hold request.
   always @(posedge clk) data_fire <= rd_en | reset | hold_req;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [DW-1:0] ea, eb;
      logic [1:0]    ebusy;
      if (data_fire) begin
         checks = checks + 2;
         if (exp_a_q.size() == 0) begin
            errors = errors + 2;
            $display("FAIL rd_data: output presented with empty expected queue at %0t", $time);
         end else begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            if (rd_a_data !== ea) begin
               errors++;
               $display("FAIL rd_a_data at %0t: got %h expected %h", $time, rd_a_data, ea);
            end
            if (rd_b_data !== eb) begin
               errors++;
               $display("FAIL rd_b_data at %0t: got %h expected %h", $time, rd_b_data, eb);
            end
         end
      end
      if (busy_chk) begin
         checks++;
         if (exp_busy_q.size() == 0) begin
            errors++;
            $display("FAIL busy: check with empty expected queue at %0t", $time);
         end else begin
            ebusy = exp_busy_q.pop_front();
            if ({rd_a_busy, rd_b_busy} !== ebusy) begin
               errors++;
               $display("FAIL busy at %0t: got a=%b b=%b expected a=%b b=%b",
                        $time, rd_a_busy, rd_b_busy, ebusy[1], ebusy[0]);
            end
         end
      end
`ifdef WB_SB_CHECK_EN
      if (err_chk) begin
         logic [0:0] ee;
         checks++;
         if (exp_err_q.size() == 0) begin
            errors++;
            $display("FAIL sb_error: check with empty expected queue at %0t", $time);
         end else begin
            ee = exp_err_q.pop_front();
            if (sb_error !== ee[0]) begin
               errors++;
               $display("FAIL sb_error at %0t: got %b expected %b", $time, sb_error, ee[0]);
            end
         end
      end
`endif
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      reset              = 1'b0;
      wb_write_back_flag = 1'b0;
      rd_en              = 1'b0;
      sb_set_valid       = 1'b0;
      hold_req           = 1'b0;
      busy_chk           = 1'b0;
      err_chk            = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_a_q.push_back('0);
      exp_b_q.push_back('0);
   endtask

   task automatic wb(input int t, input int r, input logic [DW-1:0] d);
      wb_write_back_flag = 1'b1;
      wb_thread_index    = TB'(t);
      wb_reg_index       = RB'(r);
      wb_data            = d;
   endtask

   task automatic sbset(input int t, input int r);
      sb_set_valid  = 1'b1;
      sb_set_thread = TB'(t);
      sb_set_reg    = RB'(r);
   endtask

   task automatic set_idx(input int t, input int a, input int b);
      rd_thread_index = TB'(t);
      rd_a_index      = RB'(a);
      rd_b_index      = RB'(b);
   endtask

   task automatic rd(input int t, input int a, input int b,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb);
      set_idx(t, a, b);
      rd_en = 1'b1;
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
   endtask

   task automatic hold(input logic [DW-1:0] ea, input logic [DW-1:0] eb);
      hold_req = 1'b1;
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
   endtask

   task automatic chk_busy(input logic a, input logic b);
      busy_chk = 1'b1;
      exp_busy_q.push_back({a, b});
   endtask

   task automatic chk_err(input logic e);
      err_chk = 1'b1;
      exp_err_q.push_back(e);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // Power-on reset: read registers must come up zero.
      do_reset();
      tick();
      set_idx(0, 0, 0); chk_busy(1'b0, 1'b0);
      tick();

      // Thread isolation and 1-cycle read latency, then hold with rd_en=0.
      wb(2, 5, 64'hDEAD_BEEF); tick();
      wb(3, 5, 64'h5555);      tick();
      rd(2, 5, 0, 64'hDEAD_BEEF, 64'h0); tick();
      rd(3, 5, 0, 64'h5555, 64'h0);      tick();
      hold(64'h5555, 64'h0);             tick();

      // Register 0: writes dropped, reads zero, sets ignored.
      wb(0, 0, 64'h1234); tick();
      rd(0, 0, 0, 64'h0, 64'h0); tick();
      sbset(6, 0); tick();
      set_idx(6, 0, 0); chk_busy(1'b0, 1'b0); tick();

      // Same-cycle bypass on port B; port A reads the array.
      wb(1, 8, 64'h88); tick();
      wb(1, 7, 64'hAA); rd(1, 8, 7, 64'h88, 64'hAA); tick();

      // Busy set, then masked by same-cycle write-back with bypass.
      sbset(4, 3); tick();
      set_idx(4, 3, 4); chk_busy(1'b1, 1'b0); tick();
      wb(4, 3, 64'h4433); rd(4, 3, 3, 64'h4433, 64'h4433); chk_busy(1'b0, 1'b0); tick();
      set_idx(4, 3, 3); chk_busy(1'b0, 1'b0); tick();

      // Set and clear of different entries in one cycle; a same-cycle
      // set does not show as busy until the next cycle.
      sbset(4, 11); tick();
      sbset(4, 12); wb(4, 11, 64'hB11); set_idx(4, 11, 12); chk_busy(1'b0, 1'b0); tick();
      chk_busy(1'b0, 1'b1); tick();

      // Same-entry set and clear: set wins, write still lands.
      sbset(0, 9); wb(0, 9, 64'h99); tick();
      rd(0, 9, 9, 64'h99, 64'h99); chk_busy(1'b1, 1'b1); tick();

      // Mid-operation reset drops pending bits and ignores wb/set inputs.
      wb(7, 4, 64'h74); tick();
      sbset(7, 1); tick();
      sbset(7, 2); tick();
      do_reset(); sbset(7, 3); wb(7, 4, 64'hBAD); tick();
      set_idx(7, 1, 2); chk_busy(1'b0, 1'b0);
`ifdef WB_SB_CHECK_EN
      chk_err(1'b0);
`endif
      tick();
      set_idx(7, 3, 3); chk_busy(1'b0, 1'b0); tick();
      rd(7, 4, 0, 64'h74, 64'h0); tick();

`ifdef WB_SB_CHECK_EN
      // Matched write-back is clean; unmatched one is flagged and sticks.
      sbset(5, 7); tick();
      wb(5, 7, 64'h57); tick();
      chk_err(1'b0); wb(5, 6, 64'h56); tick();
      chk_err(1'b1); tick();
      chk_err(1'b1); tick();
`endif

      tick();
      tick();

      // Every queued expectation must have been consumed.
      checks++;
      if ((exp_a_q.size() != 0) || (exp_busy_q.size() != 0) || (exp_err_q.size() != 0)) begin
         errors++;
         $display("FAIL queues_drained: data=%0d busy=%0d err=%0d entries left, expected 0",
                  exp_a_q.size(), exp_busy_q.size(), exp_err_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
